// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU definitions for the fetch sequencer: FSM state encoding and
// default address constants (reset vector, interrupt vector, step size).
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2
  } fetch_state_t;

  localparam int unsigned DEFAULT_SIZE         = 16;
  localparam int unsigned DEFAULT_INCREMENT    = 2;
  localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'h0000;
  localparam logic [15:0] DEFAULT_IRQ_VECTOR   = 16'h0010;

endpackage

// File: rtl/fetch_sequencer_next_address_mux.sv
// Combinational priority select of the next PC when leaving DECODE:
// interrupt vector, exception return, branch target, sequential step.
// Also produces the return address that an interrupt entry would save.
module next_address_mux
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned     SIZE       = DEFAULT_SIZE,
  parameter int unsigned     INCREMENT  = DEFAULT_INCREMENT,
  parameter logic [SIZE-1:0] IRQ_VECTOR = SIZE'(DEFAULT_IRQ_VECTOR)
) (
  input  logic [SIZE-1:0] pc_address,
  input  logic [SIZE-1:0] branch_target,
  input  logic [SIZE-1:0] epc,
  input  logic            branch_taken,
  input  logic            irq_take,
  input  logic            eret_take,
  output logic [SIZE-1:0] next_address,
  output logic [SIZE-1:0] epc_candidate
);

  logic [SIZE-1:0] seq_address_s;

  // Sequential step wraps silently at the top of the address space.
  assign seq_address_s = pc_address + SIZE'(INCREMENT);

  // Priority: interrupt, then return, then branch, then fall-through.
  always_comb begin
    epc_candidate = branch_taken ? branch_target : seq_address_s;
    if (irq_take) begin
      next_address = IRQ_VECTOR;
    end else if (eret_take) begin
      next_address = epc;
    end else if (branch_taken) begin
      next_address = branch_target;
    end else begin
      next_address = seq_address_s;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives PC hold/load and next address, sequences
// BOOT -> FETCH -> DECODE, and owns the one-deep interrupt state.
// Interrupt support (epc, ie, irqAck) is built only when the macro
// FETCH_SEQ_IRQ_EN is defined; otherwise irq/eret are ignored.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned     SIZE         = DEFAULT_SIZE,
  parameter int unsigned     INCREMENT    = DEFAULT_INCREMENT,
  parameter logic [SIZE-1:0] RESET_VECTOR = SIZE'(DEFAULT_RESET_VECTOR),
  parameter logic [SIZE-1:0] IRQ_VECTOR   = SIZE'(DEFAULT_IRQ_VECTOR)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [SIZE-1:0] pcAddress,
  output logic [SIZE-1:0] nextAddress,
  output logic            pcHold,
  output logic            memReq,
  input  logic            memReady,
  output logic            instrValid,
  input  logic            stall,
  input  logic            branchTaken,
  input  logic [SIZE-1:0] branchTarget,
  input  logic            irq,
  input  logic            eret,
  output logic            irqAck,
  output logic [SIZE-1:0] epc
);

  fetch_state_t    state_r;
  logic [SIZE-1:0] mux_next_s;
  logic [SIZE-1:0] epc_candidate_s;
  logic [SIZE-1:0] epc_value_s;
  logic            irq_take_s;
  logic            eret_take_s;

`ifdef FETCH_SEQ_IRQ_EN
  logic [SIZE-1:0] epc_r;
  logic            ie_r;

  assign irq_take_s  = irq & ie_r;
  assign eret_take_s = eret;
  assign epc_value_s = epc_r;
  assign epc         = epc_r;
`else
  // Interrupts compiled out: requests are masked and epc reads as zero.
  assign irq_take_s  = irq & 1'b0;
  assign eret_take_s = eret & 1'b0;
  assign epc_value_s = {SIZE{1'b0}};
  assign epc         = epc_candidate_s & {SIZE{1'b0}};
`endif

  next_address_mux #(
    .SIZE       (SIZE),
    .INCREMENT  (INCREMENT),
    .IRQ_VECTOR (IRQ_VECTOR)
  ) u_next_address_mux (
    .pc_address    (pcAddress),
    .branch_target (branchTarget),
    .epc           (epc_value_s),
    .branch_taken  (branchTaken),
    .irq_take      (irq_take_s),
    .eret_take     (eret_take_s),
    .next_address  (mux_next_s),
    .epc_candidate (epc_candidate_s)
  );

  // FSM state plus epc/ie, which only change on the edge leaving DECODE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= BOOT;
`ifdef FETCH_SEQ_IRQ_EN
      epc_r   <= {SIZE{1'b0}};
      ie_r    <= 1'b1;
`endif
    end else begin
      case (state_r)
        BOOT: begin
          state_r <= FETCH;
        end
        FETCH: begin
          if (memReady) begin
            state_r <= DECODE;
          end
        end
        DECODE: begin
          if (!stall) begin
            state_r <= FETCH;
`ifdef FETCH_SEQ_IRQ_EN
            if (irq_take_s) begin
              epc_r <= epc_candidate_s;
              ie_r  <= 1'b0;
            end else if (eret_take_s) begin
              ie_r  <= 1'b1;
            end
`endif
          end
        end
        default: begin
          state_r <= BOOT;
        end
      endcase
    end
  end

  // Per-state outputs; an illegal encoding behaves like BOOT while recovering.
  always_comb begin
    nextAddress = pcAddress;
    pcHold      = 1'b1;
    memReq      = 1'b0;
    instrValid  = 1'b0;
    irqAck      = 1'b0;
    case (state_r)
      BOOT: begin
        nextAddress = RESET_VECTOR;
        pcHold      = 1'b0;
      end
      FETCH: begin
        memReq = 1'b1;
        pcHold = 1'b1;
      end
      DECODE: begin
        instrValid = 1'b1;
        if (stall) begin
          pcHold = 1'b1;
        end else begin
          pcHold      = 1'b0;
          nextAddress = mux_next_s;
          irqAck      = irq_take_s;
        end
      end
      default: begin
        nextAddress = RESET_VECTOR;
        pcHold      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer. Models the PC register as the
// environment around the sequencer; expectations come from a constant table
// (with values for both the interrupt-enabled and interrupt-less builds).
module tb_fetch_sequencer;

`ifdef FETCH_SEQ_IRQ_EN
  localparam bit E = 1'b1;
`else
  localparam bit E = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        st;
    logic        mr;
    logic        bt;
    logic [15:0] tgt;
    logic        irq;
    logic        eret;
    logic [15:0] pc;
    logic [15:0] nxt;
    logic        hold;
    logic        req;
    logic        valid;
    logic        ack;
    logic [15:0] epc;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pcAddress = 16'hABCD;
  logic [15:0] nextAddress;
  logic        pcHold;
  logic        memReq;
  logic        memReady = 1'b0;
  logic        instrValid;
  logic        stall = 1'b0;
  logic        branchTaken = 1'b0;
  logic [15:0] branchTarget = 16'h0000;
  logic        irq = 1'b0;
  logic        eret = 1'b0;
  logic        irqAck;
  logic [15:0] epc;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  fetch_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .pcAddress    (pcAddress),
    .nextAddress  (nextAddress),
    .pcHold       (pcHold),
    .memReq       (memReq),
    .memReady     (memReady),
    .instrValid   (instrValid),
    .stall        (stall),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .irq          (irq),
    .eret         (eret),
    .irqAck       (irqAck),
    .epc          (epc)
  );

  always #5 clock = ~clock;

  // PC register around the sequencer: loads nextAddress unless held.
  always @(posedge clock) begin
    if (!pcHold) pcAddress <= nextAddress;
  end

  function automatic vec_t mk(input logic rst, st, mr, bt, input logic [15:0] tgt,
                              input logic irq_i, eret_i, input logic [15:0] pc, nxt,
                              input logic hold, req, valid, ack, input logic [15:0] epc_i);
    vec_t v;
    v.rst = rst; v.st = st; v.mr = mr; v.bt = bt; v.tgt = tgt;
    v.irq = irq_i; v.eret = eret_i; v.pc = pc; v.nxt = nxt;
    v.hold = hold; v.req = req; v.valid = valid; v.ack = ack; v.epc = epc_i;
    return v;
  endfunction

  task automatic check(input int idx, input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL step %0d %s: got %h, expected %h", idx, name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare at negedge.
  task automatic apply(input int idx, input vec_t v);
    vec_t e;
    @(posedge clock);
    #1;
    reset = v.rst; stall = v.st; memReady = v.mr; branchTaken = v.bt;
    branchTarget = v.tgt; irq = v.irq; eret = v.eret;
    exp_q.push_back(v);
    @(negedge clock);
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL step %0d scoreboard: got empty queue, expected an entry", idx);
    end else begin
      e = exp_q.pop_front();
      check(idx, "pcAddress",   pcAddress,           e.pc);
      check(idx, "nextAddress", nextAddress,         e.nxt);
      check(idx, "pcHold",      {15'd0, pcHold},     {15'd0, e.hold});
      check(idx, "memReq",      {15'd0, memReq},     {15'd0, e.req});
      check(idx, "instrValid",  {15'd0, instrValid}, {15'd0, e.valid});
      check(idx, "irqAck",      {15'd0, irqAck},     {15'd0, e.ack});
      check(idx, "epc",         epc,                 e.epc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] p1, p2, p3, p4, p5, p6, epc1, epc2, epc3;
    p1 = E ? 16'h0010 : 16'h0022;  epc1 = E ? 16'h0022 : 16'h0000;
    p2 = E ? 16'h0012 : 16'h0024;
    p3 = E ? 16'h0022 : 16'h0026;
    p4 = E ? 16'h0010 : 16'h0200;  epc2 = E ? 16'h0200 : 16'h0000;
    p5 = E ? 16'h0200 : 16'h0202;
    p6 = E ? 16'h0010 : 16'h0204;  epc3 = E ? 16'h0202 : 16'h0000;

    //            rst st mr bt tgt       irq er pc        nxt                      hd rq vl ack epc
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000,                0, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000,                0, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000,                0, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000,                1, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0002,                0, 0, 1, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0002, 16'h0002,                1, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0002, 16'h0004,                0, 0, 1, 0, 16'h0000));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 0, 16'h0004, 16'h0004,              1, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0004, 16'h0004,                1, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0004, 16'h0006,                0, 0, 1, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0006, 16'h0006,                1, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 1, 16'h0100, 0, 0, 16'h0006, 16'h0100,                0, 0, 1, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0100, 16'h0100,                1, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 1, 16'hFFFE, 0, 0, 16'h0100, 16'hFFFE,                0, 0, 1, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 0, 16'hFFFE, 16'hFFFE,                1, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 0, 16'hFFFE, 16'h0000,                0, 0, 1, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000,                1, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 1, 16'h0020, 0, 0, 16'h0000, 16'h0020,                0, 0, 1, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0020, 16'h0020,                1, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 1, 0, 16'h0020, E ? 16'h0010 : 16'h0022, 0, 0, 1, E, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 0, p1,       p1,                      1, 1, 0, 0, epc1));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 1, 0, p1,       E ? 16'h0012 : 16'h0024, 0, 0, 1, 0, epc1));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 0, p2,       p2,                      1, 1, 0, 0, epc1));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 1, p2,       E ? 16'h0022 : 16'h0026, 0, 0, 1, 0, epc1));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 0, p3,       p3,                      1, 1, 0, 0, epc1));
    tbl.push_back(mk(1, 1, 1, 1, 16'h0200, 1, 0, p3,       p3,                      1, 0, 1, 0, epc1));
    tbl.push_back(mk(1, 1, 1, 1, 16'h0200, 1, 0, p3,       p3,                      1, 0, 1, 0, epc1));
    tbl.push_back(mk(1, 0, 1, 1, 16'h0200, 1, 0, p3,       E ? 16'h0010 : 16'h0200, 0, 0, 1, E, epc1));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 0, p4,       p4,                      1, 1, 0, 0, epc2));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 1, 1, p4,       E ? 16'h0200 : 16'h0202, 0, 0, 1, 0, epc2));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 0, p5,       p5,                      1, 1, 0, 0, epc2));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 1, 0, p5,       E ? 16'h0010 : 16'h0204, 0, 0, 1, E, epc2));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 0, p6,       p6,                      1, 1, 0, 0, epc3));

    foreach (tbl[i]) apply(i, tbl[i]);

    // Reset during a FETCH wait: reset values in the same cycle, then reboot.
    apply(100, mk(0, 0, 0, 0, 16'h0000, 0, 0, p6,       16'h0000, 0, 0, 0, 0, 16'h0000));
    apply(101, mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000));
    apply(102, mk(1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000));
    apply(103, mk(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000));
    // ie must be back to 1 after reset: this interrupt is taken.
    apply(104, mk(1, 0, 1, 0, 16'h0000, 1, 0, 16'h0000, E ? 16'h0010 : 16'h0002, 0, 0, 1, E, 16'h0000));
    apply(105, mk(1, 0, 1, 0, 16'h0000, 0, 0, E ? 16'h0010 : 16'h0002, E ? 16'h0010 : 16'h0002,
                  1, 1, 0, 0, E ? 16'h0002 : 16'h0000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control block that drives the CPU program counter and sequences instruction fetch. It decides every cycle whether the PC holds or loads, and selects the next address: reset vector, sequential increment, branch target, interrupt vector or exception return. It sits between the PC register, the instruction-memory port and the decode stage. It owns the one-deep interrupt state: the return address (epc) and the interrupt-enable flag.

## Interface
- SIZE, 16, address width
- INCREMENT, 2, sequential step in address units
- RESET_VECTOR, 16'h0000, first fetch address after reset
- IRQ_VECTOR, 16'h0010, interrupt handler entry address
- clock  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low; asserting it forces the reset state immediately
- pcAddress  in  SIZE  current PC output
- nextAddress  out  SIZE  address to load into the PC
- pcHold  out  1  1 = PC keeps its last loaded address; 0 = PC loads nextAddress on the next edge
- memReq  out  1  fetch request at pcAddress
- memReady  in  1  fetch data valid this cycle
- instrValid  out  1  fetched instruction presented to decode
- stall  in  1  decode cannot accept; hold the current instruction
- branchTaken  in  1  redirect to branchTarget
- branchTarget  in  SIZE  redirect address
- irq  in  1  level interrupt request
- eret  in  1  return from interrupt
- irqAck  out  1  one-cycle pulse when an interrupt is taken
- epc  out  SIZE  saved return address

## Operation
- States: BOOT, FETCH, DECODE. Registered state: state, epc, ie.
- BOOT:
  - nextAddress = RESET_VECTOR, pcHold = 0, memReq = 0, instrValid = 0.
  - Go to FETCH on the next edge.
- FETCH:
  - memReq = 1, pcHold = 1, instrValid = 0.
  - memReady = 1 → go to DECODE. Otherwise stay in FETCH, with no limit on wait length.
- DECODE:
  - instrValid = 1, memReq = 0.
  - stall = 1 → pcHold = 1 and stay in DECODE. irq, eret and branchTaken are not acted on.
  - stall = 0 → pcHold = 0 and go to FETCH. nextAddress is chosen by priority:
    1. irq & ie → IRQ_VECTOR; epc ← (branchTaken ? branchTarget : pcAddress+INCREMENT); ie ← 0; irqAck = 1.
    2. eret → epc; ie ← 1.
    3. branchTaken → branchTarget.
    4. otherwise → pcAddress+INCREMENT.
- irq & !ie is ignored. A simultaneous eret then wins and re-enables interrupts.
- Arithmetic: pcAddress+INCREMENT is truncated to SIZE bits (wraps 0xFFFE+2 → 0x0000). No overflow flag.
- memReady outside FETCH is ignored.
- nextAddress takes the BOOT or DECODE selection. In FETCH, and in DECODE with stall = 1, it equals pcAddress (don't-care while pcHold = 1).

## Timing
- Reset values (outputs while reset = 0): state BOOT, nextAddress = RESET_VECTOR, pcHold = 0, memReq = 0, instrValid = 0, irqAck = 0, epc = 0, ie = 1.
- Reset mid-fetch or mid-decode aborts immediately. After release: BOOT for 1 cycle, then FETCH at RESET_VECTOR.
- nextAddress, pcHold, memReq, instrValid and irqAck are combinational from state and current inputs. epc and ie update on the edge that leaves DECODE.
- Minimum throughput: 2 cycles per instruction (FETCH with memReady = 1, then DECODE).
- Each wait cycle with memReady = 0 adds 1 cycle. Each stall cycle adds 1 cycle.
- The redirect takes effect on the edge leaving DECODE; the following FETCH uses the new pcAddress.

## Configuration
- FETCH_SEQ_IRQ_EN defined: interrupt logic present as described.
- Undefined:
  - irq and eret are ignored; irqAck is tied 0; epc is tied 0; ie is removed.
  - Priority reduces to branchTaken, then increment.

## Structure
- Shared cpu package holds:
  - the state encoding (BOOT/FETCH/DECODE, 2 bits);
  - RESET_VECTOR and IRQ_VECTOR defaults;
  - INCREMENT.
- One sub-module, next_address_mux: purely combinational priority select of nextAddress and the epc candidate.
- The FSM and the epc/ie registers stay in fetch_sequencer.

## Test plan
- Release reset with memReady = 1 and no other events → pcAddress 0x0000, 0x0002, 0x0004. instrValid high every second cycle; pcHold = 0 on each DECODE cycle.
- memReady low for 3 cycles in FETCH at 0x0004 → memReq and pcHold stay 1, pcAddress stays 0x0004, instrValid stays 0. The instruction is presented 1 cycle after memReady rises.
- Redirect and wrap:
  - branchTaken with branchTarget = 0x0100 at pcAddress 0x0006 → next FETCH at 0x0100.
  - At pcAddress 0xFFFE with no branch → next FETCH at 0x0000.
- Interrupt entry and return:
  - irq at pcAddress 0x0020 with ie = 1 → nextAddress 0x0010, irqAck high for exactly 1 cycle, epc = 0x0022, ie = 0.
  - A second irq in the handler is ignored.
  - eret → next FETCH at 0x0022, ie = 1.
- stall = 1 for 2 DECODE cycles with irq and branchTaken asserted → instrValid held, pcHold = 1, irqAck = 0. Once stall drops, the interrupt is taken that cycle with epc = branchTarget.
- Reset asserted during a FETCH wait → outputs at reset values in the same cycle, epc = 0, ie = 1. After release: BOOT, then fetch at RESET_VECTOR.
